// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: one-outstanding req/ack fetcher feeding a DEPTH-entry
// prefetch FIFO, with load-use stall and taken-branch redirect (flush + drain).
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    output logic                       imem_req_o,
    output logic [31:0]                imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [31:0]                imem_rdata_i,
    input  logic                       stall_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic                       inst_valid_o,
    output logic [31:0]                inst_out_o,
    output logic [31:0]                pc_out_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef enum logic [0:0] {StFetch, StDrain} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       drain_addr_q, drain_addr_d;
    logic [31:0]       inst_mem_q [DEPTH];
    logic [31:0]       pc_mem_q   [DEPTH];
    logic              req, push, pop;

    // Request is forced low while reset is asserted so the bus sees no fetch.
    always_comb begin
        req          = rst_ni & ((state_q == StDrain) | (count_q < CntW'(DEPTH)));
        imem_req_o   = req;
        imem_addr_o  = (state_q == StDrain) ? drain_addr_q : fetch_pc_q;
        inst_valid_o = (count_q != '0);
        inst_out_o   = inst_valid_o ? inst_mem_q[rd_ptr_q] : 32'h0;
        pc_out_o     = inst_valid_o ? pc_mem_q[rd_ptr_q] : 32'h0;
        occupancy_o  = count_q;
        push         = (state_q == StFetch) & req & imem_ack_i & ~redirect_i;
        pop          = inst_valid_o & ~stall_i & ~redirect_i;
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        if (redirect_i) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            // An un-acked request must still complete on the bus; its word is thrown away.
            if (state_q == StFetch && req && !imem_ack_i) begin
                drain_addr_d = fetch_pc_q;
                state_d      = StDrain;
            end
        end else begin
            if (state_q == StDrain && imem_ack_i) begin
                state_d = StFetch;
            end
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PtrW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StFetch;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    // Entry storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata_i;
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

endmodule
